// File: rtl/fmc_psram_slave_if.sv
// Host-side strobe bundle for the PSRAM-style FMC target.
// The multiplexed data/address pins stay a plain inout on the target itself.
interface fmc_psram_slave_if;
  logic cs_ni;
  logic oe_ni;
  logic we_ni;
  logic adv_ni;
  logic wait_o;

  modport master (
    output cs_ni,
    output oe_ni,
    output we_ni,
    output adv_ni,
    input  wait_o
  );

  modport slave (
    input  cs_ni,
    input  oe_ni,
    input  we_ni,
    input  adv_ni,
    output wait_o
  );
endinterface

// File: rtl/fmc_psram_slave.sv
// Synchronous multiplexed-bus PSRAM-style memory target with fixed access latency
// and incrementing bursts; all strobes are sampled on the rising edge of clk_i.
module fmc_psram_slave #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 16,
  parameter int Latency   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  inout  wire  [DataWidth-1:0] data_io,
  fmc_psram_slave_if.slave     bus,
  output logic [1:0]           dbg_state_o,
  output logic                 dbg_drive_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LAT  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int CntW = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Latency - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] rptr_q, rptr_d;
  logic [AddrWidth-1:0] wptr_q, wptr_d;
  logic                 wait_q, wait_d;
  logic [DataWidth-1:0] rdata_q;
  logic                 rd_en, wr_en;
  logic [AddrWidth-1:0] rd_addr;
  logic                 drive;

  logic [DataWidth-1:0] mem [2**AddrWidth];

  // Address phase wins in every state, so a new burst can restart mid-burst.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    wait_d  = wait_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_addr = rptr_q;
    if (bus.cs_ni) begin
      state_d = IDLE;
      wait_d  = 1'b0;
    end else if (!bus.adv_ni) begin
      addr_d  = data_io[AddrWidth-1:0];
      wptr_d  = data_io[AddrWidth-1:0];
      cnt_d   = '0;
      state_d = LAT;
      wait_d  = 1'b1;
    end else begin
      case (state_q)
        LAT: begin
          if (cnt_q == CntLast) begin
            // Prefetch so word0 is on the bus for the first data edge.
            state_d = DATA;
            wait_d  = 1'b0;
            rd_en   = 1'b1;
            rd_addr = addr_q;
            rptr_d  = addr_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (!bus.we_ni) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + 1'b1;
          end
          if (!bus.oe_ni) begin
            rd_en  = 1'b1;
            rptr_d = rptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      wait_q  <= wait_d;
    end
  end

  // Memory contents survive reset; a reset edge only blocks the write.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) begin
      mem[wptr_q] <= data_io;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[rd_addr];
    end
  end

  assign drive       = !bus.cs_ni && !bus.oe_ni && (state_q == DATA);
  assign data_io     = drive ? rdata_q : {DataWidth{1'bz}};
  assign bus.wait_o  = wait_q;
  assign dbg_state_o = state_q;
  assign dbg_drive_o = drive;

endmodule

// File: tb/tb_fmc_psram_slave.sv
// Directed bench for fmc_psram_slave: the driver queues the expected per-cycle
// observation, and a negedge monitor pops and compares it against the pins.
module tb_fmc_psram_slave;
  localparam int W   = 21;
  localparam int LAT = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LAT  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic        clk = 1'b0;
  logic        rst_ni;
  wire  [15:0] data_io;
  logic        host_en;
  logic [15:0] host_d;
  logic [1:0]  dbg_state;
  logic        dbg_drive;

  logic [W-1:0] exp_q[$];
  logic [15:0]  bd[4];
  int           n_checks = 0;
  int           n_errors = 0;

  fmc_psram_slave_if bus ();

  assign data_io = host_en ? host_d : 16'hzzzz;

  fmc_psram_slave #(
    .DataWidth(16),
    .AddrWidth(16),
    .Latency  (LAT)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .data_io    (data_io),
    .bus        (bus),
    .dbg_state_o(dbg_state),
    .dbg_drive_o(dbg_drive)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, got=running required=finished");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of pins (for the upcoming edge) and queue what the host
  // should see just before that edge.
  task automatic cyc(input logic rst, input logic cs, input logic adv,
                     input logic oe, input logic we, input logic hen,
                     input logic [15:0] hd, input logic chk,
                     input logic [1:0] st, input logic drv, input logic wt,
                     input logic [15:0] ed);
    @(posedge clk);
    #1;
    rst_ni     = rst;
    bus.cs_ni  = cs;
    bus.adv_ni = adv;
    bus.oe_ni  = oe;
    bus.we_ni  = we;
    host_en    = hen;
    host_d     = hd;
    exp_q.push_back({chk, st, drv, wt, ed});
  endtask

  task automatic write_burst(input logic [15:0] a, input int n);
    cyc(1, 0, 0, 1, 1, 1, a, 0, S_IDLE, 0, 0, 16'h0);
    repeat (LAT) cyc(1, 0, 1, 1, 0, 1, bd[0], 0, S_LAT, 0, 1, 16'h0);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 1, 0, 1, bd[i], 0, S_DATA, 0, 0, 16'h0);
    cyc(1, 1, 1, 1, 1, 0, 16'h0, 0, S_DATA, 0, 0, 16'h0);
  endtask

  task automatic read_burst(input logic [15:0] a, input int n);
    cyc(1, 0, 0, 1, 1, 1, a, 0, S_IDLE, 0, 0, 16'h0);
    repeat (LAT) cyc(1, 0, 1, 0, 1, 0, 16'h0, 0, S_LAT, 0, 1, 16'h0);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 1, 0, 16'h0, 1, S_DATA, 1, 0, bd[i]);
    cyc(1, 1, 1, 1, 1, 0, 16'h0, 0, S_DATA, 0, 0, 16'h0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (dbg_state !== e[19:18]) begin
        n_errors++;
        $display("FAIL state t=%0t got=%0d required=%0d", $time, dbg_state, e[19:18]);
      end
      n_checks++;
      if (bus.wait_o !== e[16]) begin
        n_errors++;
        $display("FAIL wait_o t=%0t got=%0b required=%0b", $time, bus.wait_o, e[16]);
      end
      n_checks++;
      if (dbg_drive !== e[17]) begin
        n_errors++;
        $display("FAIL bus_drive t=%0t got=%0b required=%0b", $time, dbg_drive, e[17]);
      end
      if (e[20]) begin
        n_checks++;
        if (data_io !== e[15:0]) begin
          n_errors++;
          $display("FAIL read_data t=%0t got=%h required=%h", $time, data_io, e[15:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst_ni     = 1'b0;
    bus.cs_ni  = 1'b1;
    bus.adv_ni = 1'b1;
    bus.oe_ni  = 1'b1;
    bus.we_ni  = 1'b1;
    host_en    = 1'b0;
    host_d     = 16'h0;
    repeat (3) @(posedge clk);

    // reset state, and idle with oe low keeps the bus released
    cyc(1, 1, 1, 1, 1, 0, 16'h0, 0, S_IDLE, 0, 0, 16'h0);
    cyc(1, 1, 1, 0, 1, 0, 16'h0, 0, S_IDLE, 0, 0, 16'h0);

    // write burst and read-backs at two start addresses
    bd[0] = 16'h6789; bd[1] = 16'hABCD; bd[2] = 16'hABAC;
    write_burst(16'h1234, 3);
    cyc(1, 1, 1, 0, 1, 0, 16'h0, 0, S_IDLE, 0, 0, 16'h0);
    read_burst(16'h1234, 2);
    bd[0] = 16'hABCD; bd[1] = 16'hABAC;
    read_burst(16'h1235, 2);
    bd[0] = 16'h6789; bd[1] = 16'hABCD; bd[2] = 16'hABAC;
    read_burst(16'h1234, 3);

    // pointer wrap
    bd[0] = 16'h5555; bd[1] = 16'h0A0A;
    write_burst(16'hFFFF, 2);
    read_burst(16'hFFFF, 2);

    // reset during a write burst: later beats must not land
    bd[0] = 16'h1111; bd[1] = 16'h2222; bd[2] = 16'h3333; bd[3] = 16'h4444;
    write_burst(16'h2000, 4);
    cyc(1, 0, 0, 1, 1, 1, 16'h2000, 0, S_IDLE, 0, 0, 16'h0);
    repeat (LAT) cyc(1, 0, 1, 1, 0, 1, 16'hAAAA, 0, S_LAT, 0, 1, 16'h0);
    cyc(1, 0, 1, 1, 0, 1, 16'hAAAA, 0, S_DATA, 0, 0, 16'h0);
    cyc(0, 0, 1, 1, 0, 1, 16'hBBBB, 0, S_DATA, 0, 0, 16'h0);
    cyc(1, 0, 1, 1, 0, 1, 16'hCCCC, 0, S_IDLE, 0, 0, 16'h0);
    cyc(1, 0, 1, 1, 0, 1, 16'hDDDD, 0, S_IDLE, 0, 0, 16'h0);
    cyc(1, 1, 1, 1, 1, 0, 16'h0, 0, S_IDLE, 0, 0, 16'h0);
    bd[0] = 16'hAAAA;
    read_burst(16'h2000, 4);

    // reset during a read burst: bus released on the next cycle
    cyc(1, 0, 0, 1, 1, 1, 16'h2000, 0, S_IDLE, 0, 0, 16'h0);
    repeat (LAT) cyc(1, 0, 1, 0, 1, 0, 16'h0, 0, S_LAT, 0, 1, 16'h0);
    cyc(1, 0, 1, 0, 1, 0, 16'h0, 1, S_DATA, 1, 0, 16'hAAAA);
    cyc(0, 0, 1, 0, 1, 0, 16'h0, 1, S_DATA, 1, 0, 16'h2222);
    cyc(1, 0, 1, 0, 1, 0, 16'h0, 0, S_IDLE, 0, 0, 16'h0);
    cyc(1, 1, 1, 0, 1, 0, 16'h0, 0, S_IDLE, 0, 0, 16'h0);
    cyc(1, 1, 1, 1, 1, 0, 16'h0, 0, S_IDLE, 0, 0, 16'h0);

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got=%0d required=0 pending entries", exp_q.size());
    end

    // report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
